// File: rtl/pic_int_sequencer.sv
// INTA handshake sequencer between the priority resolver / ISR and the data bus buffer.
// Define PIC_SEQ_AEOI_EN to enable the auto-EOI strobe on eoi_clear.
module pic_int_sequencer #(
    parameter int N_IRQ       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_bar,
    input  logic                       init_pulse,
    input  logic [N_IRQ-1:0]           irq_req,
    input  logic [8-$clog2(N_IRQ)-1:0] icw2_base,
    input  logic                       aeoi_cfg,
    input  logic                       INTA_bar,
    output logic                       INT_TO_CPU,
    output logic [N_IRQ-1:0]           irr_clear,
    output logic [N_IRQ-1:0]           isr_set,
    output logic [N_IRQ-1:0]           eoi_clear,
    output logic [7:0]                 vector_out,
    output logic                       vector_oe,
    output logic                       end_of_seq,
    output logic                       ack_abort
);

    localparam int ID_W = $clog2(N_IRQ);

    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    state_t            state, state_next;
    logic              inta_s1, inta_s2, inta_s3;
    logic              inta_fall, inta_rise;
    logic [15:0]       wd, wd_next;
    logic              timeout;
    logic [ID_W-1:0]   id_q, id_next, req_id;
    logic              spur_q, spur_next;
    logic [N_IRQ-1:0]  req_lowest;
    logic              int_q, int_next;
    logic [N_IRQ-1:0]  irr_q, irr_next;
    logic [N_IRQ-1:0]  isr_q, isr_next;
    logic [N_IRQ-1:0]  eoi_q, eoi_next;
    logic [7:0]        vec_q, vec_next;
    logic              oe_q, oe_next;
    logic              eos_q, eos_next;
    logic              abort_q, abort_next;

    // INTA_bar is asynchronous: two synchroniser flops plus one edge-history flop.
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            inta_s1 <= 1'b1;
            inta_s2 <= 1'b1;
            inta_s3 <= 1'b1;
        end else begin
            inta_s1 <= INTA_bar;
            inta_s2 <= inta_s1;
            inta_s3 <= inta_s2;
        end
    end

    assign inta_fall = inta_s3 & ~inta_s2;
    assign inta_rise = ~inta_s3 & inta_s2;
    assign timeout   = (wd == 16'(ACK_TIMEOUT - 1));

    // Lowest set bit wins when more than one request bit is presented.
    assign req_lowest = irq_req & (~irq_req + N_IRQ'(1));

    always_comb begin
        req_id = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (req_lowest[i]) begin
                req_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        id_next    = id_q;
        spur_next  = spur_q;
        int_next   = 1'b0;
        irr_next   = '0;
        isr_next   = '0;
        eoi_next   = '0;
        vec_next   = vec_q;
        oe_next    = oe_q;
        eos_next   = 1'b0;
        abort_next = 1'b0;

        if (init_pulse) begin
            state_next = IDLE;
            oe_next    = 1'b0;
            vec_next   = '0;
        end else if (state != IDLE && timeout) begin
            state_next = IDLE;
            oe_next    = 1'b0;
            abort_next = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    int_next = |irq_req;
                    if (inta_fall) begin
                        int_next   = 1'b0;
                        state_next = ACK1;
                        if (|irq_req) begin
                            id_next   = req_id;
                            spur_next = 1'b0;
                            irr_next  = req_lowest;
                            isr_next  = req_lowest;
                        end else begin
                            id_next   = ID_W'(N_IRQ - 1);
                            spur_next = 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (inta_rise) begin
                        state_next = GAP;
                    end
                end
                GAP: begin
                    if (inta_fall) begin
                        state_next = ACK2;
                        oe_next    = 1'b1;
                        vec_next   = {icw2_base, id_q};
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        state_next = IDLE;
                        oe_next    = 1'b0;
                        eos_next   = 1'b1;
`ifdef PIC_SEQ_AEOI_EN
                        if (aeoi_cfg && !spur_q) begin
                            eoi_next = N_IRQ'(1) << id_q;
                        end
`endif
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // The watchdog only runs while a handshake is in progress.
        wd_next = (state_next != state || state == IDLE) ? 16'd0 : wd + 16'd1;
    end

`ifndef PIC_SEQ_AEOI_EN
    logic unused_aeoi;
    assign unused_aeoi = aeoi_cfg ^ spur_q;
`endif

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state   <= IDLE;
            wd      <= '0;
            id_q    <= '0;
            spur_q  <= 1'b0;
            int_q   <= 1'b0;
            irr_q   <= '0;
            isr_q   <= '0;
            eoi_q   <= '0;
            vec_q   <= '0;
            oe_q    <= 1'b0;
            eos_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_next;
            wd      <= wd_next;
            id_q    <= id_next;
            spur_q  <= spur_next;
            int_q   <= int_next;
            irr_q   <= irr_next;
            isr_q   <= isr_next;
            eoi_q   <= eoi_next;
            vec_q   <= vec_next;
            oe_q    <= oe_next;
            eos_q   <= eos_next;
            abort_q <= abort_next;
        end
    end

    assign INT_TO_CPU = int_q;
    assign irr_clear  = irr_q;
    assign isr_set    = isr_q;
    assign eoi_clear  = eoi_q;
    assign vector_out = vec_q;
    assign vector_oe  = oe_q;
    assign end_of_seq = eos_q;
    assign ack_abort  = abort_q;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Bench for pic_int_sequencer: three instances (N_IRQ 8/16/2) share one INTA_bar and are
// compared against a behavioural handshake model.
module tb_pic_int_sequencer;

    localparam int TO8 = 16;

    logic clk = 1'b0;
    logic reset_bar = 1'b0;
    logic init_pulse = 1'b0;
    logic aeoi_cfg = 1'b0;
    logic INTA_bar = 1'b1;

    logic [7:0]  irq8 = '0;
    logic [4:0]  base8 = '0;
    logic        int8, oe8, eos8, abort8;
    logic [7:0]  irr8, isr8, eoi8, vec8;

    logic [15:0] irq16 = '0;
    logic [3:0]  base16 = '0;
    logic        int16, oe16, eos16, abort16;
    logic [15:0] irr16, isr16, eoi16;
    logic [7:0]  vec16;

    logic [1:0]  irq2 = '0;
    logic [6:0]  base2 = '0;
    logic        int2, oe2, eos2, abort2;
    logic [1:0]  irr2, isr2, eoi2;
    logic [7:0]  vec2;

    int errors = 0;
    int checks = 0;

    int n_irr = 0, n_isr = 0, n_eoi = 0, n_eos = 0, n_abort = 0;
    logic [7:0] last_irr = '0, last_isr = '0, last_eoi = '0, last_vec8 = '0;
    logic [7:0] last_vec16 = '0, last_vec2 = '0;

    always #5 clk = ~clk;

    pic_int_sequencer #(.N_IRQ(8), .ACK_TIMEOUT(TO8)) dut8 (
        .clk(clk), .reset_bar(reset_bar), .init_pulse(init_pulse), .irq_req(irq8),
        .icw2_base(base8), .aeoi_cfg(aeoi_cfg), .INTA_bar(INTA_bar), .INT_TO_CPU(int8),
        .irr_clear(irr8), .isr_set(isr8), .eoi_clear(eoi8), .vector_out(vec8),
        .vector_oe(oe8), .end_of_seq(eos8), .ack_abort(abort8));

    pic_int_sequencer #(.N_IRQ(16), .ACK_TIMEOUT(255)) dut16 (
        .clk(clk), .reset_bar(reset_bar), .init_pulse(init_pulse), .irq_req(irq16),
        .icw2_base(base16), .aeoi_cfg(aeoi_cfg), .INTA_bar(INTA_bar), .INT_TO_CPU(int16),
        .irr_clear(irr16), .isr_set(isr16), .eoi_clear(eoi16), .vector_out(vec16),
        .vector_oe(oe16), .end_of_seq(eos16), .ack_abort(abort16));

    pic_int_sequencer #(.N_IRQ(2), .ACK_TIMEOUT(255)) dut2 (
        .clk(clk), .reset_bar(reset_bar), .init_pulse(init_pulse), .irq_req(irq2),
        .icw2_base(base2), .aeoi_cfg(aeoi_cfg), .INTA_bar(INTA_bar), .INT_TO_CPU(int2),
        .irr_clear(irr2), .isr_set(isr2), .eoi_clear(eoi2), .vector_out(vec2),
        .vector_oe(oe2), .end_of_seq(eos2), .ack_abort(abort2));

    // Strobe scoreboard: counts active cycles and remembers the last value of each strobe.
    always @(posedge clk) begin
        #1;
        if (irr8 != 0) begin n_irr++; last_irr = irr8; end
        if (isr8 != 0) begin n_isr++; last_isr = isr8; end
        if (eoi8 != 0) begin n_eoi++; last_eoi = eoi8; end
        if (eos8) n_eos++;
        if (abort8) n_abort++;
        if (oe8) last_vec8 = vec8;
        if (oe16) last_vec16 = vec16;
        if (oe2) last_vec2 = vec2;
    end

    function automatic int ref_id(input logic [31:0] req, input int n);
        for (int i = 0; i < n; i++) if (req[i]) return i;
        return n - 1;
    endfunction

    function automatic logic [7:0] ref_vec(input int base, input int id, input int n);
        return 8'(base * n + id);
    endfunction

    function automatic int ref_eoi_count(input logic aeoi, input logic [7:0] req);
`ifdef PIC_SEQ_AEOI_EN
        return (aeoi && req != 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        INTA_bar = 1'b1;
        init_pulse = 1'b0;
        reset_bar = 1'b0;
        repeat (3) @(negedge clk);
        reset_bar = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic inta_pulse(input int low_cyc, input int high_cyc);
        @(negedge clk);
        INTA_bar = 1'b0;
        repeat (low_cyc) @(negedge clk);
        INTA_bar = 1'b1;
        repeat (high_cyc) @(negedge clk);
    endtask

    task automatic test_reset();
        irq8 = 8'h10;
        @(negedge clk);
        reset_bar = 1'b0;
        #1;
        checks++;
        if ({int8, irr8, isr8, eoi8, vec8, oe8, eos8, abort8} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs8: got %h expected 0", {int8, irr8, isr8, eoi8, vec8, oe8, eos8, abort8});
        end
        checks++;
        if ({int16, vec16, oe16, int2, vec2, oe2} !== 20'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs16_2: got %h expected 0", {int16, vec16, oe16, int2, vec2, oe2});
        end
        repeat (2) @(negedge clk);
        reset_bar = 1'b1;
        @(negedge clk);
        checks++;
        if (int8 !== 1'b1) begin errors++; $display("[TB] FAIL reset_int_after: got %b expected 1", int8); end
    endtask

    task automatic test_basic();
        int irr0, isr0, eos0, abort0, eoi0;
        do_reset();
        aeoi_cfg = 1'b0;
        irq8 = 8'h04; base8 = 5'h08;
        irq16 = 16'h0400; base16 = 4'h3;
        irq2 = 2'b10; base2 = 7'h15;
        repeat (2) @(negedge clk);
        checks++;
        if (int8 !== 1'b1) begin errors++; $display("[TB] FAIL basic_int: got %b expected 1", int8); end
        irr0 = n_irr; isr0 = n_isr; eos0 = n_eos; abort0 = n_abort; eoi0 = n_eoi;
        inta_pulse(5, 5);
        checks++;
        if (int8 !== 1'b0) begin errors++; $display("[TB] FAIL basic_int_held: got %b expected 0", int8); end
        @(negedge clk);
        INTA_bar = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (oe8 !== 1'b1 || vec8 !== 8'h42) begin
            errors++;
            $display("[TB] FAIL basic_vector: got oe=%b vec=%h expected oe=1 vec=42", oe8, vec8);
        end
        INTA_bar = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (n_irr - irr0 !== 1 || last_irr !== 8'h04) begin
            errors++;
            $display("[TB] FAIL basic_irr: got %0d cycles val %h expected 1 cycle val 04", n_irr - irr0, last_irr);
        end
        checks++;
        if (n_isr - isr0 !== 1 || last_isr !== 8'h04) begin
            errors++;
            $display("[TB] FAIL basic_isr: got %0d cycles val %h expected 1 cycle val 04", n_isr - isr0, last_isr);
        end
        checks++;
        if (n_eos - eos0 !== 1 || n_abort - abort0 !== 0 || n_eoi - eoi0 !== 0) begin
            errors++;
            $display("[TB] FAIL basic_eos: got eos=%0d abort=%0d eoi=%0d expected 1 0 0", n_eos - eos0, n_abort - abort0, n_eoi - eoi0);
        end
        checks++;
        if (oe8 !== 1'b0 || int8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_end_state: got oe=%b int=%b expected oe=0 int=1", oe8, int8);
        end
        checks++;
        if (last_vec16 !== 8'h3A) begin errors++; $display("[TB] FAIL vec16: got %h expected 3a", last_vec16); end
        checks++;
        if (last_vec2 !== ref_vec(21, 1, 2)) begin
            errors++;
            $display("[TB] FAIL vec2: got %h expected %h", last_vec2, ref_vec(21, 1, 2));
        end
    endtask

    task automatic test_spurious();
        int irr0, isr0, eoi0, eos0;
        do_reset();
        aeoi_cfg = 1'b1;
        irq8 = 8'h08; base8 = 5'h15;
        repeat (2) @(negedge clk);
        irq8 = 8'h00;
        irr0 = n_irr; isr0 = n_isr; eoi0 = n_eoi; eos0 = n_eos;
        inta_pulse(5, 5);
        inta_pulse(5, 6);
        checks++;
        if (n_irr - irr0 !== 0 || n_isr - isr0 !== 0) begin
            errors++;
            $display("[TB] FAIL spur_strobes: got irr=%0d isr=%0d expected 0 0", n_irr - irr0, n_isr - isr0);
        end
        checks++;
        if (last_vec8 !== 8'hAF) begin errors++; $display("[TB] FAIL spur_vector: got %h expected af", last_vec8); end
        checks++;
        if (n_eoi - eoi0 !== 0 || n_eos - eos0 !== 1) begin
            errors++;
            $display("[TB] FAIL spur_eoi: got eoi=%0d eos=%0d expected 0 1", n_eoi - eoi0, n_eos - eos0);
        end
    endtask

    task automatic test_aeoi();
        int eoi0, exp_n;
        logic [7:0] exp_val;
        do_reset();
        irq8 = 8'h80; base8 = 5'h02;
        aeoi_cfg = 1'b1;
        exp_n = ref_eoi_count(1'b1, 8'h80);
        exp_val = (exp_n == 1) ? 8'h80 : 8'h00;
        eoi0 = n_eoi;
        repeat (2) @(negedge clk);
        inta_pulse(5, 5);
        inta_pulse(5, 6);
        checks++;
        if (n_eoi - eoi0 !== exp_n || last_eoi !== exp_val) begin
            errors++;
            $display("[TB] FAIL aeoi_on: got %0d cycles val %h expected %0d cycles val %h", n_eoi - eoi0, last_eoi, exp_n, exp_val);
        end
        aeoi_cfg = 1'b0;
        eoi0 = n_eoi;
        inta_pulse(5, 5);
        inta_pulse(5, 6);
        checks++;
        if (n_eoi - eoi0 !== 0) begin errors++; $display("[TB] FAIL aeoi_off: got %0d cycles expected 0", n_eoi - eoi0); end
    endtask

    task automatic test_timeout();
        int k, irr0;
        bit seen;
        do_reset();
        aeoi_cfg = 1'b0;
        irq8 = 8'h04; base8 = 5'h01;
        repeat (2) @(negedge clk);
        @(negedge clk);
        INTA_bar = 1'b0;
        repeat (5) @(negedge clk);
        INTA_bar = 1'b1;
        k = 0;
        seen = 0;
        while (k < 100 && !seen) begin
            @(negedge clk);
            k++;
            if (abort8) seen = 1;
        end
        checks++;
        if (!seen || k !== 3 + TO8) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got seen=%0d after %0d cycles expected %0d", seen, k, 3 + TO8);
        end
        checks++;
        if (oe8 !== 1'b0 || int8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_abort_cycle: got oe=%b int=%b expected 0 0", oe8, int8);
        end
        @(negedge clk);
        checks++;
        if (abort8 !== 1'b0 || int8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_after: got abort=%b int=%b expected 0 1", abort8, int8);
        end
        irr0 = n_irr;
        inta_pulse(5, 5);
        checks++;
        if (n_irr - irr0 !== 1) begin errors++; $display("[TB] FAIL timeout_idle: got %0d irr cycles expected 1", n_irr - irr0); end
    endtask

    task automatic test_init_and_async_reset();
        int eos0;
        bit oe_bad;
        do_reset();
        irq8 = 8'h04; base8 = 5'h08;
        repeat (2) @(negedge clk);
        inta_pulse(5, 5);
        eos0 = n_eos;
        @(negedge clk);
        INTA_bar = 1'b0;
        repeat (2) @(negedge clk);
        init_pulse = 1'b1;
        @(negedge clk);
        init_pulse = 1'b0;
        oe_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (oe8 !== 1'b0) oe_bad = 1;
            @(negedge clk);
        end
        checks++;
        if (oe_bad) begin errors++; $display("[TB] FAIL init_oe: got oe=1 expected oe held 0"); end
        INTA_bar = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (n_eos - eos0 !== 0 || int8 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL init_idle: got eos=%0d int=%b expected 0 1", n_eos - eos0, int8);
        end
        inta_pulse(5, 5);
        @(negedge clk);
        INTA_bar = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (oe8 !== 1'b1) begin errors++; $display("[TB] FAIL ack2_oe: got %b expected 1", oe8); end
        reset_bar = 1'b0;
        #1;
        checks++;
        if ({int8, irr8, isr8, eoi8, vec8, oe8, eos8, abort8} !== 36'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected 0", {int8, irr8, isr8, eoi8, vec8, oe8, eos8, abort8});
        end
        INTA_bar = 1'b1;
        repeat (2) @(negedge clk);
        reset_bar = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int irr0, eoi0, eos0, exp_id, exp_n;
        logic [7:0] exp_vec8, exp_vec16, exp_vec2, exp_hot;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            irq8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            base8 = 5'($urandom);
            irq16 = 16'($urandom);
            base16 = 4'($urandom);
            irq2 = 2'($urandom);
            base2 = 7'($urandom);
            aeoi_cfg = 1'($urandom);
            repeat (2) @(negedge clk);
            checks++;
            if (int8 !== (irq8 != 0)) begin
                errors++;
                $display("[TB] FAIL rnd_int[%0d]: got %b expected %b", it, int8, irq8 != 0);
            end
            exp_id = ref_id({24'd0, irq8}, 8);
            exp_hot = (irq8 != 0) ? 8'(1 << exp_id) : 8'h00;
            exp_vec8 = ref_vec(int'(base8), exp_id, 8);
            exp_vec16 = ref_vec(int'(base16), ref_id({16'd0, irq16}, 16), 16);
            exp_vec2 = ref_vec(int'(base2), ref_id({30'd0, irq2}, 2), 2);
            exp_n = ref_eoi_count(aeoi_cfg, irq8);
            irr0 = n_irr; eoi0 = n_eoi; eos0 = n_eos;
            inta_pulse($urandom_range(4, 7), $urandom_range(4, 7));
            inta_pulse($urandom_range(4, 7), 6);
            checks++;
            if (n_irr - irr0 !== ((irq8 != 0) ? 1 : 0) || (irq8 != 0 && last_irr !== exp_hot)) begin
                errors++;
                $display("[TB] FAIL rnd_irr[%0d]: got %0d cycles val %h expected val %h", it, n_irr - irr0, last_irr, exp_hot);
            end
            checks++;
            if (last_vec8 !== exp_vec8 || last_vec16 !== exp_vec16 || last_vec2 !== exp_vec2) begin
                errors++;
                $display("[TB] FAIL rnd_vec[%0d]: got %h %h %h expected %h %h %h", it, last_vec8, last_vec16, last_vec2, exp_vec8, exp_vec16, exp_vec2);
            end
            checks++;
            if (n_eoi - eoi0 !== exp_n || (exp_n == 1 && last_eoi !== exp_hot) || n_eos - eos0 !== 1) begin
                errors++;
                $display("[TB] FAIL rnd_eoi[%0d]: got eoi=%0d val %h eos=%0d expected eoi=%0d val %h eos=1", it, n_eoi - eoi0, last_eoi, n_eos - eos0, exp_n, exp_hot);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_spurious();
        test_aeoi();
        test_timeout();
        test_init_and_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
